// File: rtl/ladder_io_pkg.sv
// Shared constants and state encoding for the Montgomery-ladder I/O stage.
package ladder_io_pkg;

    localparam int WORD_W    = 32;
    localparam int OP_W      = 1024;
    localparam int WPO       = OP_W / WORD_W;
    localparam int NUM_OPS   = 5;
    localparam int JOB_WORDS = WPO * NUM_OPS;

    localparam logic [2:0] OP_X  = 3'd0;
    localparam logic [2:0] OP_M  = 3'd1;
    localparam logic [2:0] OP_E  = 3'd2;
    localparam logic [2:0] OP_R  = 3'd3;
    localparam logic [2:0] OP_R2 = 3'd4;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_START  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UNLOAD = 2'd3
    } state_t;

endpackage

// File: rtl/msb_index32.sv
// Combinational priority encoder: index of the highest set bit of a 32-bit word.
module msb_index32 (
    input  logic [31:0] word,
    output logic [4:0]  idx
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (word[i]) idx = 5'(i);
        end
    end

endmodule

// File: rtl/ladder_io_stage.sv
// Streams operands into the ladder core, starts it, and streams the 1024-bit result back out.
import ladder_io_pkg::*;

module ladder_io_stage (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_W-1:0]   out_data,
    output logic                out_last,
    output logic [OP_W-1:0]     ld_x,
    output logic [OP_W-1:0]     ld_m,
    output logic [OP_W-1:0]     ld_e,
    output logic [OP_W-1:0]     ld_r,
    output logic [OP_W-1:0]     ld_r2,
    output logic [31:0]         ld_lene,
    output logic                ld_start,
    input  logic                ld_done,
    input  logic [OP_W-1:0]     ld_result,
    output logic                busy
);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        word_cnt;
    logic [4:0]        out_idx;
    logic              e_nonzero;
    logic [OP_W-1:0]   res_q;
    logic [4:0]        in_msb;

    logic              in_fire;
    logic              out_fire;
    logic              last_in;
    logic [2:0]        op_sel;
    logic [4:0]        word_idx;
    logic [9:0]        bit_base;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign op_sel   = word_cnt[7:5];
    assign word_idx = word_cnt[4:0];
    assign bit_base = {word_idx, 5'd0};
    assign last_in  = (word_cnt == 8'(JOB_WORDS - 1));

    msb_index32 u_msb (
        .word (in_data),
        .idx  (in_msb)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_LOAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: begin
                // An all-zero exponent skips the ladder entirely: x^0 = 1.
                if (in_fire && last_in) state_nxt = e_nonzero ? ST_START : ST_UNLOAD;
            end
            ST_START:  state_nxt = ST_WAIT;
            ST_WAIT:   if (ld_done) state_nxt = ST_UNLOAD;
            ST_UNLOAD: if (out_fire && out_idx == 5'd31) state_nxt = ST_LOAD;
            default:   state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        ld_start  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (state)
            ST_LOAD:  in_ready = 1'b1;
            ST_START: ld_start = 1'b1;
            ST_UNLOAD: begin
                out_valid = 1'b1;
                out_data  = res_q[{out_idx, 5'd0} +: WORD_W];
                out_last  = (out_idx == 5'd31);
            end
            default: ;
        endcase
    end

    assign busy = !(state == ST_LOAD && word_cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt  <= '0;
            out_idx   <= '0;
            e_nonzero <= 1'b0;
            ld_x      <= '0;
            ld_m      <= '0;
            ld_e      <= '0;
            ld_r      <= '0;
            ld_r2     <= '0;
            ld_lene   <= '0;
            res_q     <= '0;
        end else begin
            if (in_fire) begin
                word_cnt <= last_in ? 8'd0 : 8'(word_cnt + 8'd1);
                case (op_sel)
                    OP_X:    ld_x[bit_base +: WORD_W]  <= in_data;
                    OP_M:    ld_m[bit_base +: WORD_W]  <= in_data;
                    OP_E:    ld_e[bit_base +: WORD_W]  <= in_data;
                    OP_R:    ld_r[bit_base +: WORD_W]  <= in_data;
                    OP_R2:   ld_r2[bit_base +: WORD_W] <= in_data;
                    default: ;
                endcase
                if (word_cnt == 8'd0) ld_lene <= '0;
                // e arrives LS word first, so the last nonzero word sets the bit-length.
                if (op_sel == OP_E && in_data != '0) begin
                    ld_lene   <= 32'({word_idx, in_msb});
                    e_nonzero <= 1'b1;
                end
                if (last_in && !e_nonzero) res_q <= OP_W'(1);
            end
            // The ladder overwrites ld_result one cycle after done, so capture now.
            if (state == ST_WAIT && ld_done) res_q <= ld_result;
            if (out_fire) begin
                out_idx <= out_idx + 5'd1;
                if (out_idx == 5'd31) begin
                    word_cnt  <= '0;
                    e_nonzero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ladder_io_stage.sv
// Directed bench for ladder_io_stage with a latency-programmable ladder stub.
module tb_ladder_io_stage;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_last;
    logic [1023:0] ld_x, ld_m, ld_e, ld_r, ld_r2;
    logic [31:0]   ld_lene;
    logic          ld_start;
    logic          ld_done = 1'b0;
    logic [1023:0] ld_result = '0;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int last_acc_cyc = 0;
    int last_out_cyc = 0;
    int lad_lat = 6;
    int lad_cnt = 0;
    int lad_run = 0;
    bit lad_after = 1'b0;
    int spur_req = 0;
    int spur_ack = 0;
    logic [1023:0] exp_op [5];

    always #5 clk = ~clk;

    ladder_io_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .ld_x      (ld_x),
        .ld_m      (ld_m),
        .ld_e      (ld_e),
        .ld_r      (ld_r),
        .ld_r2     (ld_r2),
        .ld_lene   (ld_lene),
        .ld_start  (ld_start),
        .ld_done   (ld_done),
        .ld_result (ld_result),
        .busy      (busy)
    );

    function automatic logic [1023:0] lad_res(input int run);
        logic [1023:0] r;
        for (int j = 0; j < 32; j++) r[j*32 +: 32] = {4'(run), 4'h0, 8'(j), 16'h0102};
        return r;
    endfunction

    function automatic logic [31:0] op_word(input int seed, input int o, input int k);
        return 32'hA500_0000 ^ (32'(seed) << 16) ^ (32'(o) << 8) ^ 32'(k);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ld_start) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
        end
    end

    // Ladder stub: done after lad_lat cycles, result changes the cycle after done.
    always @(negedge clk) begin
        ld_done = 1'b0;
        if (spur_req != spur_ack) begin
            ld_done   = 1'b1;
            ld_result = {32{32'hFFFF_FFFF}};
            spur_ack  = spur_req;
        end else if (lad_cnt == 1) begin
            ld_done   = 1'b1;
            ld_result = lad_res(lad_run);
            lad_cnt   = 0;
            lad_after = 1'b1;
        end else begin
            if (lad_after) ld_result = ~lad_res(lad_run);
            lad_after = 1'b0;
            if (lad_cnt > 1) lad_cnt = lad_cnt - 1;
        end
        if (ld_start) begin
            lad_run = lad_run + 1;
            lad_cnt = lad_lat;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_op(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        int w = 0;
        for (int i = 31; i >= 0; i--) if (got[i*32 +: 32] !== exp[i*32 +: 32]) w = i;
        check(tag, 64'(got[w*32 +: 32]), 64'(exp[w*32 +: 32]));
    endtask

    task automatic send_word(input logic [31:0] d, input int gap);
        int t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid     = 1'b0;
            last_acc_cyc = cyc;
        end
    endtask

    task automatic send_job(input int seed, input logic [1023:0] e_val, input int maxgap);
        logic [31:0] w;
        for (int o = 0; o < 5; o++) begin
            for (int k = 0; k < 32; k++) begin
                w = (o == 2) ? e_val[k*32 +: 32] : op_word(seed, o, k);
                exp_op[o][k*32 +: 32] = w;
                send_word(w, (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
            end
        end
    endtask

    task automatic recv_job(input string tag, input logic [1023:0] exp_res,
                            input int stall_at, input int stall_len);
        for (int j = 0; j < 32; j++) begin
            int t = 0;
            @(negedge clk);
            while (!out_valid && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (!out_valid) begin
                check({tag, "_valid_timeout"}, 0, 1);
                return;
            end
            if (j == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    check({tag, "_stall_data"}, out_data, exp_res[j*32 +: 32]);
                    check({tag, "_stall_last"}, out_last, 0);
                    @(negedge clk);
                end
            end
            check({tag, "_data"}, out_data, exp_res[j*32 +: 32]);
            check({tag, "_last"}, out_last, (j == 31));
            check({tag, "_in_ready_busy"}, in_ready, 0);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready    = 1'b0;
            last_out_cyc = cyc;
        end
        @(negedge clk);
        check({tag, "_valid_after"}, out_valid, 0);
        check({tag, "_in_ready_after"}, in_ready, 1);
    endtask

    task automatic check_ops(input string tag);
        check_op({tag, "_x"}, ld_x, exp_op[0]);
        check_op({tag, "_m"}, ld_m, exp_op[1]);
        check_op({tag, "_e"}, ld_e, exp_op[2]);
        check_op({tag, "_r"}, ld_r, exp_op[3]);
        check_op({tag, "_r2"}, ld_r2, exp_op[4]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_ld_start", ld_start, 0);
        check("rst_lene", ld_lene, 0);
        check_op("rst_x", ld_x, '0);

        // Spurious done while idle must be ignored.
        spur_req++;
        repeat (3) @(negedge clk);
        check("spur_busy", busy, 0);
        check("spur_out_valid", out_valid, 0);

        // e = 65537, with an output stall at word 3
        s0 = start_cnt;
        send_job(1, 1024'h0001_0001, 0);
        @(negedge clk);
        check("j1_start", ld_start, 1);
        check("j1_lene", ld_lene, 16);
        check("j1_in_ready", in_ready, 0);
        check("j1_busy", busy, 1);
        check_ops("j1");
        @(negedge clk);
        #1;
        check("j1_start_one", ld_start, 0);
        check("j1_start_cyc", start_cyc, last_acc_cyc);
        recv_job("j1", lad_res(1), 3, 5);
        check("j1_start_cnt", start_cnt, s0 + 1);
        check_op("j1_x_hold", ld_x, exp_op[0]);
        check("j1_lene_hold", ld_lene, 16);

        // Top bit of e set
        send_job(2, 1024'(1) << 1023, 0);
        @(negedge clk);
        check("j2_start", ld_start, 1);
        check("j2_lene", ld_lene, 1023);
        check_op("j2_e", ld_e, exp_op[2]);
        recv_job("j2", lad_res(2), -1, 0);

        // e == 0: result is 1 with no ladder run
        s0 = start_cnt;
        send_job(3, '0, 0);
        @(negedge clk);
        check("j3_no_start", ld_start, 0);
        check("j3_out_valid", out_valid, 1);
        check("j3_lene", ld_lene, 0);
        recv_job("j3", 1024'd1, -1, 0);
        check("j3_start_cnt", start_cnt, s0);

        // e == 1
        send_job(4, 1024'd1, 0);
        @(negedge clk);
        check("j4_start", ld_start, 1);
        check("j4_lene", ld_lene, 0);
        recv_job("j4", lad_res(3), -1, 0);

        // Reset during WAIT abandons the run; its late done is ignored.
        lad_lat = 30;
        send_job(5, 1024'h3, 0);
        @(negedge clk);
        check("j5_start", ld_start, 1);
        check("j5_lene", ld_lene, 1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("j5_rst_in_ready", in_ready, 1);
        check("j5_rst_busy", busy, 0);
        check("j5_rst_start", ld_start, 0);
        check("j5_rst_lene", ld_lene, 0);
        check_op("j5_rst_x", ld_x, '0);
        repeat (30) @(negedge clk);
        check("j5_late_done_busy", busy, 0);
        check("j5_late_done_valid", out_valid, 0);
        lad_lat = 6;
        send_job(6, 1024'h0000_0400_0000_0000, 0);
        @(negedge clk);
        check("j6_start", ld_start, 1);
        check("j6_lene", ld_lene, 42);
        check_ops("j6");
        recv_job("j6", lad_res(5), -1, 0);

        // Back-to-back jobs with random input gaps
        send_job(7, 1024'h1234_5678, 3);
        @(negedge clk);
        check("j7_start", ld_start, 1);
        check("j7_lene", ld_lene, 28);
        check_ops("j7");
        fork
            recv_job("j7", lad_res(6), -1, 0);
            send_job(8, 1024'(5) << 160, 3);
        join
        @(negedge clk);
        check("j8_start", ld_start, 1);
        check("j8_lene", ld_lene, 162);
        check_ops("j8");
        @(negedge clk);
        #1;
        check("j8_start_after_unload", (start_cyc > last_out_cyc), 1);
        recv_job("j8", lad_res(7), -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ladder_io_stage.md
Name: ladder_io_stage

Overview:
- Front/back-end stage for the Montgomery-ladder exponentiation core.
- Assembles the five 1024-bit operands x, m, e, r, r2 from a 32-bit valid/ready input stream and derives the exponent bit-length.
- Starts the ladder, captures its 1024-bit result, and streams the result out as 32-bit words.
- Sits between the DMA/bus interface and the ladder core.

Parameters:
- WORD_W, 32, stream word width.
- OP_W, 1024, operand width.
- WPO, OP_W/WORD_W = 32, words per operand.
- NUM_OPS, 5, operands per job.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  stage accepts input word
- in_data  in  32  input word
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts output word
- out_data  out  32  output word
- out_last  out  1  high on final (32nd) output word
- ld_x, ld_m, ld_e, ld_r, ld_r2  out  1024 each  operands to ladder
- ld_lene  out  32  index of highest set bit of e
- ld_start  out  1  one-cycle start pulse to ladder
- ld_done  in  1  ladder done pulse
- ld_result  in  1024  ladder result, valid only in the ld_done cycle
- busy  out  1  high in any state except LOAD with word counter 0

Behaviour:
- Clock and reset: one clock, clk. Synchronous active-high reset: state=LOAD, counters=0, all ld_* operand registers=0, ld_lene=0, ld_start=0, out_valid=0, out_data=0, out_last=0, e_nonzero flag=0.
- Input order: operands x, m, e, r, r2, each 32 words, least-significant word first.
  - Word k of an operand goes to bits [32k+31:32k].
  - Total of 160 words per job. There is no in_last; framing is by count only.
- FSM states: LOAD, START, WAIT, UNLOAD.
- LOAD:
  - in_ready=1.
  - A word is accepted when in_valid & in_ready.
  - 8-bit word counter 0..159. Operand select = counter/32; word index = counter%32.
  - On an accepted e word with nonzero data: ld_lene <= 32*idx + msb(word) and e_nonzero <= 1.
    - Words arrive least-significant first, so the last nonzero word determines ld_lene.
    - ld_lene is cleared when the first x word of a job is accepted.
  - After the 160th accepted word:
    - If e_nonzero, or the final e word was nonzero, go to START.
    - Otherwise (e==0): load the result register with 1 and go directly to UNLOAD. No ld_start is issued.
- START:
  - ld_start=1 for exactly one cycle. This is the cycle immediately after the 160th word is accepted.
  - in_ready=0. Next state is WAIT.
- WAIT:
  - in_ready=0.
  - When ld_done=1, capture ld_result into the internal 1024-bit result register in that same cycle (the ladder overwrites its result the following cycle), then go to UNLOAD.
  - ld_done outside WAIT is ignored.
- UNLOAD:
  - out_valid=1. out_data = result word j, with j=0 (least-significant) first. out_last=1 when j=31.
  - j advances only on out_valid & out_ready.
  - While out_ready=0, out_data and out_last hold stable.
  - After word 31 is accepted: out_valid=0, counters cleared, e_nonzero cleared, go to LOAD.
  - in_ready is asserted in the next cycle; no bubble beyond that.
- Operand stability: ld_x..ld_r2 and ld_lene stay stable from START until the first word of the next job is accepted.
  - Rationale: the ladder resamples its inputs continuously while idle.
- No job overlap: input is not accepted during START, WAIT or UNLOAD.
- Reset mid-operation (any state): immediate return to reset values.
  - A partially loaded job is discarded.
  - A ladder run in progress is abandoned; its later ld_done is ignored because the stage is in LOAD.
- Boundary cases:
  - e==1 gives ld_lene=0 with a start issued.
  - Top bit of e set gives ld_lene=1023.
  - Simultaneous in_valid and reset: reset wins; the word is not accepted.

Decomposition:
- Package ladder_io_pkg: WORD_W, OP_W, WPO, NUM_OPS, operand index constants (OP_X=0, OP_M=1, OP_E=2, OP_R=3, OP_R2=4), FSM state encoding.
- One sub-module, msb_index32: combinational 32-bit priority encoder returning a 5-bit index of the highest set bit. Used for the ld_lene computation.

Test Plan:
1. e=65537 (word0=0x00010001, other e words 0), arbitrary x/m/r/r2 streamed without gaps -> ld_lene=16. ld_start high exactly one cycle, one cycle after word 160. All ld_* equal the streamed values. in_ready=0 until unload completes.
2. e word31=0x80000000, others 0 -> ld_lene=1023. e = word0 0x00000001 only -> ld_lene=0 and ld_start asserted.
3. e all zero -> no ld_start. Output 32 words: 0x00000001, then 31 × 0x00000000. out_last on word 31.
4. Ladder model returns ld_result = 0x0102..., then a different value the next cycle -> stream carries the done-cycle value. Hold out_ready=0 for 5 cycles at word 3 -> out_data stable, no word skipped or duplicated, out_last only on word 31.
5. Pulse ld_done during LOAD -> ignored. Assert reset at cycle 10 of WAIT -> next cycle in_ready=1, busy=0, ld_start=0. A later ld_done is ignored. A fresh 160-word job completes correctly.
6. Two back-to-back jobs with random in_valid gaps -> second ld_start occurs only after the first job's 32nd output word. Both result streams match the model.
